// File: rtl/hyperbus_pkg.sv
// Shared definitions for the HyperBus burst FIFO.
// State encoding, command codes, width ratio and parameter checks.
package hyperbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    function automatic int calc_ratio(input int usr_w, input int hbus_w);
        return usr_w / hbus_w;
    endfunction

    function automatic bit widths_ok(
        input int usr_w,
        input int hbus_w,
        input int len_w,
        input int dat_a
    );
        return (hbus_w > 0) && (usr_w >= hbus_w) &&
               (usr_w % hbus_w == 0) && (len_w <= dat_a);
    endfunction

endpackage

// File: rtl/hyperbus_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count.
// Ports: clk, rst (sync high), push/din, pop/dout (head word), count.
module hyperbus_sync_fifo #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DSIZE-1:0] din,
    input  logic             pop,
    output logic [DSIZE-1:0] dout,
    output logic [ASIZE:0]   count
);

    localparam logic [ASIZE:0]   DEPTH = {1'b1, {ASIZE{1'b0}}};
    localparam logic [ASIZE-1:0] P_ONE = 1;
    localparam logic [ASIZE:0]   C_ONE = 1;

    logic [DSIZE-1:0] mem [2**ASIZE];
    logic [ASIZE-1:0] wr_ptr;
    logic [ASIZE-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is fine when the head leaves the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != DEPTH) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + P_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + P_ONE;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + C_ONE;
                2'b01:   count <= count - C_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hyperbus_burst_fifo.sv
// Command/TX/RX buffering and width conversion for a HyperBus controller.
// Ports: user cmd/tx/rx valid-ready streams; hbus_* native burst side.
module hyperbus_burst_fifo #(
    parameter int USR_DATA_WIDTH  = 32,
    parameter int HBUS_DATA_WIDTH = 16,
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int CMD_ASIZE       = 2,
    parameter int DAT_ASIZE       = 4,
    parameter int LEN_WIDTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_we,
    input  logic [HBUS_ADDR_WIDTH-1:0] cmd_adr,
    input  logic [LEN_WIDTH-1:0]       cmd_len,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    input  logic [USR_DATA_WIDTH-1:0]  tx_dat,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [USR_DATA_WIDTH-1:0]  rx_dat,
    output logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_o,
    output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
    input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
    output logic                       hbus_rrq,
    output logic                       hbus_wrq,
    input  logic                       hbus_ready,
    input  logic                       hbus_valid,
    input  logic                       hbus_busy
);
    import hyperbus_pkg::*;

    localparam int RATIO = calc_ratio(USR_DATA_WIDTH, HBUS_DATA_WIDTH);
    localparam int CW    = DAT_ASIZE + 1;
    localparam int BCW   = LEN_WIDTH + $clog2(RATIO) + 1;
    localparam int PW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int CMDW  = 1 + LEN_WIDTH + HBUS_ADDR_WIDTH;

    localparam logic [CW-1:0]      DDEPTH  = {1'b1, {DAT_ASIZE{1'b0}}};
    localparam logic [CMD_ASIZE:0] CDEPTH  = {1'b1, {CMD_ASIZE{1'b0}}};
    localparam logic [PW-1:0]      PH_LAST = PW'(RATIO - 1);

    if (!widths_ok(USR_DATA_WIDTH, HBUS_DATA_WIDTH, LEN_WIDTH, DAT_ASIZE))
    begin : g_bad_cfg
        $error("hyperbus_burst_fifo: illegal width parameters");
    end

    state_t                      state;
    logic                        run;
    logic [CMDW-1:0]             cmd_din;
    logic [CMDW-1:0]             cmd_dout;
    logic [CMD_ASIZE:0]          cmd_count;
    logic                        head_we;
    logic [LEN_WIDTH-1:0]        head_len;
    logic [HBUS_ADDR_WIDTH-1:0]  head_adr;
    logic [USR_DATA_WIDTH-1:0]   tx_dout;
    logic [USR_DATA_WIDTH-1:0]   rx_din;
    logic [USR_DATA_WIDTH-1:0]   rx_dout;
    logic [CW-1:0]               tx_count;
    logic [CW-1:0]               rx_count;
    logic [CW-1:0]               rx_free;
    logic [CW-1:0]               need;
    logic [USR_DATA_WIDTH-1:0]   shreg;
    logic [PW-1:0]               phase;
    logic [BCW-1:0]              beats;
    logic                        can_go;
    logic                        issue;
    logic                        wr_beat;
    logic                        rd_beat;
    logic                        word_end;
    logic                        last_beat;
    logic                        tx_pop;
    logic                        rx_push;
    logic                        rx_pop;

    // run keeps every ready low while reset is held.
    assign cmd_ready = run && (cmd_count != CDEPTH);
    assign tx_ready  = run && (tx_count != DDEPTH);
    assign rx_valid  = (rx_count != '0);
    assign rx_dat    = rx_valid ? rx_dout : '0;
    assign rx_pop    = rx_ready && rx_valid;

    assign cmd_din = {cmd_we, cmd_len, cmd_adr};
    assign {head_we, head_len, head_adr} = cmd_dout;

    // A burst starts only when all its data or space is already there.
    assign need    = CW'(head_len) + CW'(1);
    assign rx_free = DDEPTH - rx_count;
    assign can_go  = (head_we == CMD_WRITE) ? (tx_count >= need)
                                            : (rx_free >= need);
    assign issue   = (state == ST_IDLE) && (cmd_count != '0) &&
                     !hbus_busy && can_go;

    assign wr_beat   = (state == ST_WRITE) && hbus_ready;
    assign rd_beat   = (state == ST_READ) && hbus_valid;
    assign word_end  = (phase == PH_LAST);
    assign last_beat = (beats == BCW'(1));

    // The TX head moves into shreg at issue and at each word boundary.
    assign tx_pop  = (issue && (head_we == CMD_WRITE)) ||
                     (wr_beat && word_end && !last_beat);
    assign rx_push = rd_beat && word_end;
    assign rx_din  = (shreg << HBUS_DATA_WIDTH) |
                     USR_DATA_WIDTH'(hbus_dat_i);

    assign hbus_dat_o =
        shreg[USR_DATA_WIDTH-1 -: HBUS_DATA_WIDTH];

    hyperbus_sync_fifo #(.DSIZE(CMDW), .ASIZE(CMD_ASIZE)) u_cmd (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .din   (cmd_din),
        .pop   (issue),
        .dout  (cmd_dout),
        .count (cmd_count)
    );

    hyperbus_sync_fifo #(.DSIZE(USR_DATA_WIDTH), .ASIZE(DAT_ASIZE)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid && tx_ready),
        .din   (tx_dat),
        .pop   (tx_pop),
        .dout  (tx_dout),
        .count (tx_count)
    );

    hyperbus_sync_fifo #(.DSIZE(USR_DATA_WIDTH), .ASIZE(DAT_ASIZE)) u_rx (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_din),
        .pop   (rx_pop),
        .dout  (rx_dout),
        .count (rx_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            run        <= 1'b0;
            shreg      <= '0;
            phase      <= '0;
            beats      <= '0;
            hbus_adr_o <= '0;
            hbus_wrq   <= 1'b0;
            hbus_rrq   <= 1'b0;
        end else begin
            run <= 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (issue) begin
                        hbus_adr_o <= head_adr;
                        beats <= (BCW'(head_len) + BCW'(1)) * BCW'(RATIO);
                        phase <= '0;
                        if (head_we == CMD_WRITE) begin
                            shreg    <= tx_dout;
                            state    <= ST_WRITE;
                            hbus_wrq <= 1'b1;
                        end else begin
                            shreg    <= '0;
                            state    <= ST_READ;
                            hbus_rrq <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (hbus_ready) begin
                        beats <= beats - BCW'(1);
                        phase <= word_end ? '0 : phase + PW'(1);
                        if (last_beat) begin
                            state    <= ST_GAP;
                            hbus_wrq <= 1'b0;
                            shreg    <= '0;
                        end else if (word_end) begin
                            shreg <= tx_dout;
                        end else begin
                            shreg <= shreg << HBUS_DATA_WIDTH;
                        end
                    end
                end
                ST_READ: begin
                    if (hbus_valid) begin
                        beats <= beats - BCW'(1);
                        phase <= word_end ? '0 : phase + PW'(1);
                        shreg <= rx_din;
                        if (last_beat) begin
                            state    <= ST_GAP;
                            hbus_rrq <= 1'b0;
                        end
                    end
                end
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hyperbus_burst_fifo.sv
// Self-checking bench for hyperbus_burst_fifo.
// Queue-based model of beats, RX words and issued addresses.
module tb_hyperbus_burst_fifo;

    localparam int UW  = 32;
    localparam int HW  = 16;
    localparam int AW  = 32;
    localparam int LW  = 4;
    localparam int RAT = UW / HW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [UW-1:0] tx_dat = '0;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic [UW-1:0] rx_dat;
    logic [AW-1:0] hbus_adr_o;
    logic [HW-1:0] hbus_dat_o;
    logic [HW-1:0] hbus_dat_i = '0;
    logic          hbus_rrq;
    logic          hbus_wrq;
    logic          hbus_ready = 1'b0;
    logic          hbus_valid = 1'b0;
    logic          hbus_busy = 1'b0;

    int vectors = 0;
    int errors  = 0;

    logic [HW-1:0] rd_beats[$];
    logic [HW-1:0] wr_seen[$];
    logic [HW-1:0] exp_wr[$];
    logic [AW-1:0] adr_seen[$];
    logic [AW-1:0] exp_adr[$];
    logic [UW-1:0] exp_rx[$];

    bit rand_bus    = 1'b0;
    bit prev_act    = 1'b0;
    int hi_run      = 0;
    int low_run     = 0;
    int gap_seen    = 0;
    int last_hi     = 0;
    int bursts_done = 0;

    hyperbus_burst_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_adr    (cmd_adr),
        .cmd_len    (cmd_len),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_dat     (tx_dat),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_dat     (rx_dat),
        .hbus_adr_o (hbus_adr_o),
        .hbus_dat_o (hbus_dat_o),
        .hbus_dat_i (hbus_dat_i),
        .hbus_rrq   (hbus_rrq),
        .hbus_wrq   (hbus_wrq),
        .hbus_ready (hbus_ready),
        .hbus_valid (hbus_valid),
        .hbus_busy  (hbus_busy)
    );

    always #5 clk = ~clk;

    // HyperBus side: record accepted write beats, feed queued read beats.
    task automatic bus_step();
        bit act;
        act = hbus_wrq | hbus_rrq;
        if (act) begin
            if (!prev_act) begin
                adr_seen.push_back(hbus_adr_o);
                gap_seen = low_run;
                hi_run = 0;
            end
            hi_run++;
        end else begin
            if (prev_act) begin
                bursts_done++;
                last_hi = hi_run;
                low_run = 0;
            end
            low_run++;
        end
        prev_act = act;
        hbus_ready = 1'b0;
        hbus_valid = 1'b0;
        if (hbus_wrq) begin
            hbus_ready = rand_bus ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hbus_ready) wr_seen.push_back(hbus_dat_o);
        end
        if (hbus_rrq && rd_beats.size() > 0) begin
            hbus_valid = rand_bus ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hbus_valid) hbus_dat_i = rd_beats.pop_front();
        end
    endtask

    task automatic tick();
        @(negedge clk);
        bus_step();
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Model: a user word goes out as RAT beats, most significant first.
    task automatic model_write(input logic [UW-1:0] w);
        for (int k = 0; k < RAT; k++)
            exp_wr.push_back(HW'(w >> (UW - HW * (k + 1))));
    endtask

    // Model: RAT consecutive read beats form one word, first beat on top.
    task automatic plan_read(input int words, input bit seq, input int start);
        logic [HW-1:0] b;
        logic [UW-1:0] w;
        for (int j = 0; j < words; j++) begin
            w = '0;
            for (int k = 0; k < RAT; k++) begin
                b = seq ? HW'(start + j * RAT + k) : HW'($urandom);
                rd_beats.push_back(b);
                w = w | (UW'(b) << (HW * (RAT - 1 - k)));
            end
            exp_rx.push_back(w);
        end
    endtask

    task automatic clear_model();
        rd_beats.delete();
        wr_seen.delete();
        exp_wr.delete();
        adr_seen.delete();
        exp_adr.delete();
        exp_rx.delete();
    endtask

    task automatic push_tx(input logic [UW-1:0] w);
        int t = 0;
        while (!tx_ready && t < 300) begin tick(); t++; end
        if (!tx_ready) begin
            vectors++; errors++;
            $display("FAIL push_tx timeout tx_ready=%b want 1", tx_ready);
            return;
        end
        tx_valid = 1'b1;
        tx_dat = w;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic push_cmd(input bit we, input logic [AW-1:0] a,
                            input int len);
        int t = 0;
        while (!cmd_ready && t < 300) begin tick(); t++; end
        if (!cmd_ready) begin
            vectors++; errors++;
            $display("FAIL push_cmd timeout cmd_ready=%b want 1", cmd_ready);
            return;
        end
        cmd_valid = 1'b1;
        cmd_we = we;
        cmd_adr = a;
        cmd_len = LW'(len);
        exp_adr.push_back(a);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic pop_rx(output logic [UW-1:0] w);
        int t = 0;
        while (!rx_valid && t < 300) begin tick(); t++; end
        w = rx_dat;
        if (!rx_valid) begin
            vectors++; errors++;
            $display("FAIL pop_rx timeout rx_valid=%b want 1", rx_valid);
            return;
        end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic wait_bursts(input int target);
        int t = 0;
        while (bursts_done < target && t < 2000) begin tick(); t++; end
        if (bursts_done < target) begin
            vectors++; errors++;
            $display("FAIL burst timeout done=%0d want %0d",
                     bursts_done, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cycles(3);
        vectors++;
        if ({cmd_ready, tx_ready, rx_valid, hbus_rrq, hbus_wrq} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {cmd_ready, tx_ready, rx_valid, hbus_rrq, hbus_wrq});
        end
        vectors++;
        if (hbus_adr_o !== '0 || hbus_dat_o !== '0) begin
            errors++;
            $display("FAIL reset_bus adr=%h dat=%h want 0",
                     hbus_adr_o, hbus_dat_o);
        end
        rst = 1'b0;
        wait_cycles(2);
        vectors++;
        if ({cmd_ready, tx_ready, rx_valid} !== 3'b110) begin
            errors++;
            $display("FAIL post_reset_ready got %b want 110",
                     {cmd_ready, tx_ready, rx_valid});
        end
    endtask

    task automatic test_write_single();
        int base = bursts_done;
        clear_model();
        rand_bus = 1'b0;
        push_tx(32'hDEADBEEF);
        model_write(32'hDEADBEEF);
        push_cmd(1'b1, 32'h100, 0);
        vectors++;
        if (hbus_wrq !== 1'b0) begin
            errors++;
            $display("FAIL wr_lat_n1 wrq=%b want 0", hbus_wrq);
        end
        tick();
        vectors++;
        if (hbus_wrq !== 1'b1 || hbus_adr_o !== 32'h100) begin
            errors++;
            $display("FAIL wr_lat_n2 wrq=%b adr=%h want 1 100",
                     hbus_wrq, hbus_adr_o);
        end
        wait_bursts(base + 1);
        vectors++;
        if (wr_seen.size() != exp_wr.size() || last_hi != RAT) begin
            errors++;
            $display("FAIL wr1_len beats=%0d hi=%0d want %0d",
                     wr_seen.size(), last_hi, RAT);
        end
        for (int i = 0; i < exp_wr.size(); i++) begin
            vectors++;
            if (wr_seen[i] !== exp_wr[i]) begin
                errors++;
                $display("FAIL wr1_beat%0d got %h want %h",
                         i, wr_seen[i], exp_wr[i]);
            end
        end
        tick();
        vectors++;
        if ({hbus_wrq, hbus_rrq} !== 2'b00) begin
            errors++;
            $display("FAIL wr1_gap got %b want 00", {hbus_wrq, hbus_rrq});
        end
    endtask

    task automatic test_back_to_back();
        int base = bursts_done;
        logic [UW-1:0] w;
        clear_model();
        for (int i = 0; i < 2; i++) begin
            w = $urandom;
            push_tx(w);
            model_write(w);
        end
        push_cmd(1'b1, 32'h200, 0);
        push_cmd(1'b1, 32'h204, 0);
        wait_bursts(base + 2);
        vectors++;
        if (gap_seen != 2) begin
            errors++;
            $display("FAIL b2b_gap idle=%0d want 2", gap_seen);
        end
        vectors++;
        if (wr_seen != exp_wr || adr_seen != exp_adr) begin
            errors++;
            $display("FAIL b2b_data beats=%p want %p adr=%p want %p",
                     wr_seen, exp_wr, adr_seen, exp_adr);
        end
    endtask

    task automatic test_read();
        int base = bursts_done;
        logic [UW-1:0] w;
        clear_model();
        plan_read(4, 1'b1, 1);
        push_cmd(1'b0, 32'h300, 3);
        wait_bursts(base + 1);
        vectors++;
        if (last_hi != 4 * RAT) begin
            errors++;
            $display("FAIL rd4_len hi=%0d want %0d", last_hi, 4 * RAT);
        end
        for (int i = 0; i < 4; i++) begin
            pop_rx(w);
            vectors++;
            if (w !== exp_rx[i]) begin
                errors++;
                $display("FAIL rd4_word%0d got %h want %h", i, w, exp_rx[i]);
            end
        end
    endtask

    task automatic test_read_latency();
        int base = bursts_done;
        int t = 0;
        bit seen_hi = 1'b0;
        bit prev_rxv = 1'b0;
        logic [UW-1:0] w;
        clear_model();
        plan_read(1, 1'b0, 0);
        push_cmd(1'b0, 32'h400, 0);
        while (!(seen_hi && !hbus_rrq) && t < 50) begin
            prev_rxv = rx_valid;
            tick();
            if (hbus_rrq) seen_hi = 1'b1;
            t++;
        end
        vectors++;
        if (!seen_hi || rx_valid !== 1'b1 || prev_rxv !== 1'b0) begin
            errors++;
            $display("FAIL rx_lat rrq_seen=%b rxv=%b prev=%b want 1 1 0",
                     seen_hi, rx_valid, prev_rxv);
        end
        wait_bursts(base + 1);
        pop_rx(w);
        vectors++;
        if (w !== exp_rx[0]) begin
            errors++;
            $display("FAIL rd1_word got %h want %h", w, exp_rx[0]);
        end
    endtask

    task automatic test_tx_gate();
        int base = bursts_done;
        logic [UW-1:0] w;
        clear_model();
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            model_write(w);
            if (i == 0) push_cmd(1'b1, 32'h500, 3);
            push_tx(w);
            if (i < 3) begin
                wait_cycles(8);
                vectors++;
                if (hbus_wrq !== 1'b0 || adr_seen.size() != 0) begin
                    errors++;
                    $display("FAIL tx_gate_%0d wrq=%b issued=%0d want 0 0",
                             i + 1, hbus_wrq, adr_seen.size());
                end
            end
        end
        wait_bursts(base + 1);
        vectors++;
        if (last_hi != 8 || wr_seen != exp_wr) begin
            errors++;
            $display("FAIL tx_gate_burst hi=%0d beats=%p want 8 %p",
                     last_hi, wr_seen, exp_wr);
        end
    endtask

    task automatic test_rx_gate();
        int base = bursts_done;
        logic [UW-1:0] w;
        clear_model();
        plan_read(14, 1'b0, 0);
        push_cmd(1'b0, 32'h600, 13);
        wait_bursts(base + 1);
        plan_read(4, 1'b0, 0);
        push_cmd(1'b0, 32'h640, 3);
        wait_cycles(10);
        vectors++;
        if (hbus_rrq !== 1'b0 || adr_seen.size() != 1) begin
            errors++;
            $display("FAIL rx_gate_hold rrq=%b issued=%0d want 0 1",
                     hbus_rrq, adr_seen.size());
        end
        for (int i = 0; i < 2; i++) begin
            pop_rx(w);
            vectors++;
            if (w !== exp_rx[0]) begin
                errors++;
                $display("FAIL rx_gate_pop%0d got %h want %h",
                         i, w, exp_rx[0]);
            end
            void'(exp_rx.pop_front());
        end
        vectors++;
        if (hbus_rrq !== 1'b0) begin
            errors++;
            $display("FAIL rx_gate_early rrq=%b want 0", hbus_rrq);
        end
        tick();
        vectors++;
        if (hbus_rrq !== 1'b1) begin
            errors++;
            $display("FAIL rx_gate_issue rrq=%b want 1", hbus_rrq);
        end
        wait_bursts(base + 2);
        for (int i = 0; i < 16; i++) begin
            pop_rx(w);
            vectors++;
            if (w !== exp_rx[i]) begin
                errors++;
                $display("FAIL rx_gate_drain%0d got %h want %h",
                         i, w, exp_rx[i]);
            end
        end
    endtask

    task automatic test_busy_reset();
        int base;
        clear_model();
        hbus_busy = 1'b1;
        for (int i = 0; i < 5; i++) push_tx($urandom);
        push_cmd(1'b1, 32'h700, 3);
        push_cmd(1'b1, 32'h780, 0);
        wait_cycles(6);
        vectors++;
        if (hbus_wrq !== 1'b0) begin
            errors++;
            $display("FAIL busy_hold wrq=%b want 0", hbus_wrq);
        end
        hbus_busy = 1'b0;
        tick();
        vectors++;
        if (hbus_wrq !== 1'b1) begin
            errors++;
            $display("FAIL busy_release wrq=%b want 1", hbus_wrq);
        end
        wait_cycles(2);
        rst = 1'b1;
        tick();
        vectors++;
        if (hbus_wrq !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort wrq=%b want 0", hbus_wrq);
        end
        tick();
        rst = 1'b0;
        wait_cycles(2);
        clear_model();
        base = bursts_done;
        vectors++;
        if ({cmd_ready, tx_ready, rx_valid} !== 3'b110) begin
            errors++;
            $display("FAIL rst_fifos got %b want 110",
                     {cmd_ready, tx_ready, rx_valid});
        end
        push_cmd(1'b1, 32'h7C0, 0);
        wait_cycles(6);
        vectors++;
        if (hbus_wrq !== 1'b0 || adr_seen.size() != 0) begin
            errors++;
            $display("FAIL rst_tx_empty wrq=%b issued=%0d want 0 0",
                     hbus_wrq, adr_seen.size());
        end
        push_tx(32'h12345678);
        model_write(32'h12345678);
        wait_bursts(base + 1);
        vectors++;
        if (wr_seen != exp_wr || adr_seen != exp_adr) begin
            errors++;
            $display("FAIL rst_fresh beats=%p want %p adr=%p want %p",
                     wr_seen, exp_wr, adr_seen, exp_adr);
        end
    endtask

    task automatic test_cmd_full();
        int base = bursts_done;
        logic [UW-1:0] w;
        clear_model();
        hbus_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            plan_read(1, 1'b0, 0);
            push_cmd(1'b0, AW'(32'h800 + 4 * i), 0);
        end
        vectors++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL cmd_full ready=%b want 0", cmd_ready);
        end
        hbus_busy = 1'b0;
        plan_read(1, 1'b0, 0);
        push_cmd(1'b0, 32'h810, 0);
        vectors++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL cmd_refill ready=%b want 0", cmd_ready);
        end
        wait_bursts(base + 5);
        vectors++;
        if (adr_seen != exp_adr) begin
            errors++;
            $display("FAIL cmd_order adr=%p want %p", adr_seen, exp_adr);
        end
        for (int i = 0; i < 5; i++) begin
            pop_rx(w);
            vectors++;
            if (w !== exp_rx[i]) begin
                errors++;
                $display("FAIL cmd_full_rx%0d got %h want %h",
                         i, w, exp_rx[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [UW-1:0] w;
        int base;
        int len;
        bit we;
        clear_model();
        rand_bus = 1'b1;
        for (int n = 0; n < 12; n++) begin
            base = bursts_done;
            we = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 15);
            if (we) begin
                for (int j = 0; j <= len; j++) begin
                    w = $urandom;
                    model_write(w);
                    push_tx(w);
                end
            end else begin
                plan_read(len + 1, 1'b0, 0);
            end
            push_cmd(we, AW'($urandom), len);
            wait_bursts(base + 1);
            if (!we) begin
                for (int j = 0; j <= len; j++) begin
                    pop_rx(w);
                    vectors++;
                    if (w !== exp_rx[0]) begin
                        errors++;
                        $display("FAIL rand%0d_rx%0d got %h want %h",
                                 n, j, w, exp_rx[0]);
                    end
                    void'(exp_rx.pop_front());
                end
            end
        end
        vectors++;
        if (wr_seen != exp_wr) begin
            errors++;
            $display("FAIL rand_wr beats=%0d want %0d",
                     wr_seen.size(), exp_wr.size());
        end
        vectors++;
        if (adr_seen != exp_adr) begin
            errors++;
            $display("FAIL rand_adr issued=%0d want %0d",
                     adr_seen.size(), exp_adr.size());
        end
        rand_bus = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_single();
        test_back_to_back();
        test_read();
        test_read_latency();
        test_tx_gate();
        test_rx_gate();
        test_busy_reset();
        test_cmd_full();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
